// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default sizing for the systolic array sequencer.
// Contents: seq_state_e (IDLE, LOAD, COMPUTE, DRAIN, DONE), default array/operand/command
// sizes, and the index/count widths derived from them.
package systolic_pkg;
    localparam int SA_N       = 16;
    localparam int SA_DW      = 8;
    localparam int SA_MAX_VEC = 256;
    localparam int SA_DRAIN   = 32;
    localparam int SA_IDX_W   = $clog2(SA_N);
    localparam int SA_VEC_W   = $clog2(SA_MAX_VEC + 1);
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} seq_state_e;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter with a terminal-count (zero) flag.
// Ports: clk, rst (async, active-high), load_i/load_val_i (load wins over dec_i),
// dec_i (decrement by one), cnt_o (current count), tc_o (count is zero).
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
    assign tc_o  = cnt_q == '0;
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: per-command sequencer for the systolic array edge. Streams one weight
// tile down the columns (row index N-1..0), issues the input vectors across the rows with
// the buffer switch on the first one, drains the array, then pulses done.
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_num_vec (command in,
// 0 vectors = load-only, clamped to MAX_VECTORS); w_valid/w_ready/w_data (weight rows);
// x_valid/x_ready/x_data (input vectors); sa_accept_w/sa_weight/sa_index (array top edge);
// sa_valid/sa_switch/sa_input (array left edge); busy; done (one-cycle pulse).
// Build option: define SEQ_PERF_CNT_EN to add perf_stall_cycles and perf_busy_cycles.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = SA_N,
    parameter int DATA_WIDTH_IN        = SA_DW,
    parameter int MAX_VECTORS          = SA_MAX_VEC,
    parameter int DRAIN_CYCLES         = SA_DRAIN,
    localparam int BW = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_IN,
    localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH),
    localparam int VW = $clog2(MAX_VECTORS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [VW-1:0] cmd_num_vec,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [BW-1:0] w_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [BW-1:0] x_data,
    output logic          sa_accept_w,
    output logic [BW-1:0] sa_weight,
    output logic [IW-1:0] sa_index,
    output logic          sa_valid,
    output logic          sa_switch,
    output logic [BW-1:0] sa_input,
    output logic          busy,
    output logic          done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]   perf_stall_cycles,
    output logic [31:0]   perf_busy_cycles
`endif
);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    seq_state_e state_q, state_d;
    logic first_q, first_d, cmd_acc, w_beat, x_beat, last_vec;
    logic idx_tc, vcnt_tc, dcnt_tc;
    logic [IW-1:0] idx, sa_index_q, sa_index_d;
    logic [VW-1:0] vcnt, num_vec;
    logic [DCW-1:0] dcnt_unused;
    logic sa_accept_w_q, sa_accept_w_d, sa_valid_q, sa_valid_d, sa_switch_q, sa_switch_d;
    logic done_q, done_d;
    logic [BW-1:0] sa_weight_q, sa_weight_d, sa_input_q, sa_input_d;

    assign cmd_ready = state_q == IDLE;
    assign w_ready   = state_q == LOAD;
    assign x_ready   = state_q == COMPUTE;
    assign busy      = state_q != IDLE;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign w_beat    = w_valid && w_ready;
    assign x_beat    = x_valid && x_ready;
    assign last_vec  = x_beat && vcnt == VW'(1);
    assign num_vec   = (cmd_num_vec > VW'(MAX_VECTORS)) ? VW'(MAX_VECTORS) : cmd_num_vec;

    // idx stops at 0 so it never wraps; vcnt keeps num_vec through LOAD for the load-only test.
    seq_down_counter #(.W(IW)) u_idx (
        .clk, .rst, .load_i(cmd_acc), .load_val_i(IW'(SYSTOLIC_ARRAY_WIDTH - 1)),
        .dec_i(w_beat && !idx_tc), .cnt_o(idx), .tc_o(idx_tc)
    );
    seq_down_counter #(.W(VW)) u_vcnt (
        .clk, .rst, .load_i(cmd_acc), .load_val_i(num_vec),
        .dec_i(x_beat), .cnt_o(vcnt), .tc_o(vcnt_tc)
    );
    seq_down_counter #(.W(DCW)) u_dcnt (
        .clk, .rst, .load_i(last_vec), .load_val_i(DCW'(DRAIN_CYCLES - 1)),
        .dec_i(state_q == DRAIN), .cnt_o(dcnt_unused), .tc_o(dcnt_tc)
    );

    always_comb begin
        state_d       = state_q;
        first_d       = cmd_acc ? 1'b1 : x_beat ? 1'b0 : first_q;
        sa_accept_w_d = w_beat;
        sa_weight_d   = w_beat ? w_data : '0;
        sa_index_d    = w_beat ? idx : '0;
        sa_valid_d    = x_beat;
        sa_switch_d   = x_beat && first_q;
        sa_input_d    = x_beat ? x_data : '0;
        done_d        = state_q == DONE;
        case (state_q)
            IDLE:    state_d = cmd_valid ? LOAD : IDLE;
            LOAD:    state_d = (w_beat && idx_tc) ? (vcnt_tc ? DONE : COMPUTE) : LOAD;
            COMPUTE: state_d = last_vec ? DRAIN : COMPUTE;
            DRAIN:   state_d = dcnt_tc ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            first_q       <= 1'b0;
            sa_accept_w_q <= 1'b0;
            sa_weight_q   <= '0;
            sa_index_q    <= '0;
            sa_valid_q    <= 1'b0;
            sa_switch_q   <= 1'b0;
            sa_input_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            sa_accept_w_q <= sa_accept_w_d;
            sa_weight_q   <= sa_weight_d;
            sa_index_q    <= sa_index_d;
            sa_valid_q    <= sa_valid_d;
            sa_switch_q   <= sa_switch_d;
            sa_input_q    <= sa_input_d;
            done_q        <= done_d;
        end
    end

    assign sa_accept_w = sa_accept_w_q;
    assign sa_weight   = sa_weight_q;
    assign sa_index    = sa_index_q;
    assign sa_valid    = sa_valid_q;
    assign sa_switch   = sa_switch_q;
    assign sa_input    = sa_input_q;
    assign done        = done_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_busy_q;
    logic stall;
    assign stall = (w_ready && !w_valid) || (x_ready && !x_valid);
    always_ff @(posedge clk or posedge rst) begin
        if (rst || cmd_acc) begin
            perf_stall_q <= '0;
            perf_busy_q  <= '0;
        end else begin
            if (stall && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
            if (busy && !(&perf_busy_q))   perf_busy_q  <= perf_busy_q + 32'd1;
        end
    end
    assign perf_stall_cycles = perf_stall_q;
    assign perf_busy_cycles  = perf_busy_q;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: randomized self-checking bench for systolic_seq_ctrl.
module tb_systolic_seq_ctrl;
    localparam int N    = 16;
    localparam int DW   = 8;
    localparam int MAXV = 256;
    localparam int DRN  = 32;
    localparam int BW   = N * DW;
    localparam int IW   = $clog2(N);
    localparam int VW   = $clog2(MAXV + 1);

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid, cmd_ready, w_valid, w_ready, x_valid, x_ready;
    logic [VW-1:0] cmd_num_vec;
    logic [BW-1:0] w_data, x_data, sa_weight, sa_input;
    logic [IW-1:0] sa_index;
    logic sa_accept_w, sa_valid, sa_switch, busy, done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_busy_cycles;
`endif

    logic exp_acc, exp_valid, exp_sw, exp_done;
    logic [BW-1:0] exp_w, exp_in;
    logic [IW-1:0] exp_idx;
    int n_chk = 0, n_fail = 0, bubbles = 0, busy_cyc = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_vec(cmd_num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .sa_accept_w(sa_accept_w), .sa_weight(sa_weight), .sa_index(sa_index),
        .sa_valid(sa_valid), .sa_switch(sa_switch), .sa_input(sa_input),
        .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clear_exp();
        exp_acc = 0; exp_valid = 0; exp_sw = 0; exp_done = 0;
        exp_w = '0; exp_in = '0; exp_idx = '0;
    endtask

    // Advance to the next falling edge and compare every registered output with the model.
    task automatic step();
        @(negedge clk);
        check("sa_accept_w", BW'(sa_accept_w), BW'(exp_acc));
        check("sa_weight", sa_weight, exp_w);
        check("sa_index", BW'(sa_index), BW'(exp_idx));
        check("sa_valid", BW'(sa_valid), BW'(exp_valid));
        check("sa_switch", BW'(sa_switch), BW'(exp_sw));
        check("sa_input", sa_input, exp_in);
        check("done", BW'(done), BW'(exp_done));
        if (sa_accept_w && sa_valid) check("ownership", BW'(1), BW'(0));
    endtask

    task automatic do_accept(input int nv_req);
        check("cmd_ready_idle", BW'(cmd_ready), BW'(1));
        check("busy_idle", BW'(busy), BW'(0));
        cmd_valid = 1; cmd_num_vec = VW'(nv_req);
        clear_exp();
        step();
        cmd_valid = 0;
        bubbles = 0; busy_cyc = 0;
    endtask

    task automatic do_load(input int pct, input int gap_at, input bit pat);
        int r = 0, gap = 0;
        while (r < N) begin
            check("w_ready", BW'(w_ready), BW'(1));
            check("x_ready_load", BW'(x_ready), BW'(0));
            clear_exp(); busy_cyc++;
            w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ((r == gap_at && gap < 3) || $urandom_range(99) < pct) begin
                w_valid = 0; bubbles++;
                if (r == gap_at) gap++;
            end else begin
                w_valid = 1;
                if (pat) w_data = {N{8'(r)}};
                exp_acc = 1; exp_w = w_data; exp_idx = IW'(N - 1 - r);
                r++;
            end
            step();
        end
        w_valid = 0;
    endtask

    task automatic do_compute(input int nv, input int pct, input bit toggle, input bit pat, input int limit);
        int v = 0, t = 0;
        while (v < nv && v < limit) begin
            check("x_ready", BW'(x_ready), BW'(1));
            check("w_ready_compute", BW'(w_ready), BW'(0));
            clear_exp(); busy_cyc++;
            x_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (toggle ? t[0] : ($urandom_range(99) < pct)) begin
                x_valid = 0; bubbles++;
            end else begin
                x_valid = 1;
                if (pat) x_data = {N{8'(v + 2)}};
                exp_valid = 1; exp_in = x_data; exp_sw = v == 0;
                v++;
            end
            t++;
            step();
        end
        x_valid = 0;
    endtask

    // Drain (only when vectors were issued), the DONE cycle, then the done pulse.
    task automatic finish_cmd(input int nv);
        clear_exp();
        if (nv > 0) begin
            check("x_ready_drain", BW'(x_ready), BW'(0));
            repeat (DRN) begin
                check("busy_drain", BW'(busy), BW'(1));
                busy_cyc++;
                step();
            end
        end
        check("w_ready_done", BW'(w_ready), BW'(0));
        check("cmd_ready_done", BW'(cmd_ready), BW'(0));
        busy_cyc++;
        exp_done = 1;
        step();
        exp_done = 0;
        check("busy_after", BW'(busy), BW'(0));
`ifdef SEQ_PERF_CNT_EN
        check("perf_stall", BW'(perf_stall_cycles), BW'(bubbles));
        check("perf_busy", BW'(perf_busy_cycles), BW'(busy_cyc));
`endif
    endtask

    task automatic run_cmd(input int nv_req, input int pct, input int gap_at, input bit toggle, input bit pat);
        int nv = nv_req > MAXV ? MAXV : nv_req;
        do_accept(nv_req);
        do_load(pct, gap_at, pat);
        do_compute(nv, pct, toggle, pat, nv);
        finish_cmd(nv);
    endtask

    initial begin
        cmd_valid = 0; cmd_num_vec = '0; w_valid = 0; w_data = '0; x_valid = 0; x_data = '0;
        clear_exp();
        step();
        check("reset_busy", BW'(busy), BW'(0));
        check("reset_cmd_ready", BW'(cmd_ready), BW'(1));
        check("reset_w_ready", BW'(w_ready), BW'(0));
        check("reset_x_ready", BW'(x_ready), BW'(0));
        rst = 0;
        run_cmd(2, 0, -1, 0, 1);
        run_cmd(6, 0, 8, 1, 0);
        run_cmd(0, 0, -1, 0, 1);
        repeat (6) run_cmd(int'($urandom_range(20)), int'($urandom_range(50)), -1, 0, 0);
        run_cmd(300, 10, -1, 0, 0);
        // Asynchronous abort in the middle of COMPUTE.
        do_accept(5);
        do_load(0, -1, 0);
        do_compute(5, 0, 0, 0, 2);
        check("pre_abort_valid", BW'(sa_valid), BW'(1));
        x_valid = 1; x_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        #2 rst = 1;
        #1;
        check("abort_sa_valid", BW'(sa_valid), BW'(0));
        check("abort_sa_input", sa_input, '0);
        check("abort_sa_accept_w", BW'(sa_accept_w), BW'(0));
        check("abort_sa_switch", BW'(sa_switch), BW'(0));
        check("abort_busy", BW'(busy), BW'(0));
        check("abort_cmd_ready", BW'(cmd_ready), BW'(1));
        x_valid = 0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", BW'(done), BW'(0));
        end
        rst = 0;
        clear_exp();
        run_cmd(3, 20, -1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the PE systolic array edge. Per command it:
  - streams one weight tile down the columns with descending row indices (A-flow), so each PE captures the weight whose index equals its ROW_ID;
  - issues the input vectors across the rows (B-flow), flagging the first vector with the double-buffer switch;
  - drains the pipeline, then pulses done.
- Sits between the tile fetch buffers and the array. Input skew is applied downstream of this block.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 16, array rows/columns (N).
- DATA_WIDTH_IN, 8, signed operand width.
- MAX_VECTORS, 256, maximum input vectors per command.
- DRAIN_CYCLES, 32, cycles after the last vector before done (covers 2N array latency).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_num_vec  in  $clog2(MAX_VECTORS+1)  vectors to compute; 0 = load-only.
- w_valid  in  1  weight row available.
- w_ready  out  1  high only in LOAD.
- w_data  in  N*DATA_WIDTH_IN  one weight row; element c goes to column c.
- x_valid  in  1  input vector available.
- x_ready  out  1  high only in COMPUTE.
- x_data  in  N*DATA_WIDTH_IN  one input vector; element r goes to row r.
- sa_accept_w  out  1  array top-edge weight-valid.
- sa_weight  out  N*DATA_WIDTH_IN  array top-edge weights.
- sa_index  out  $clog2(N)  target row index.
- sa_valid  out  1  array left-edge valid.
- sa_switch  out  1  array left-edge buffer switch.
- sa_input  out  N*DATA_WIDTH_IN  array left-edge inputs.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; all sa_* outputs 0; done 0; busy 0; counters 0. Reset asserted mid-operation aborts immediately with these values; no done pulse.
- All sa_* outputs and done are registered: exactly one cycle after the qualifying event.
- IDLE:
  - cmd_ready=1.
  - cmd_valid latches num_vec, sets idx=N-1 and moves to LOAD.
- LOAD:
  - Beat = w_valid&w_ready.
  - Each beat: next cycle sa_accept_w=1, sa_weight=w_data, sa_index=idx; then idx decrements.
  - No beat: sa_accept_w=0; sa_weight and sa_index are driven to 0 (bubble; PE chain tolerates it).
  - After the beat with idx=0:
    - num_vec=0 → DONE;
    - else → COMPUTE with first=1 and vcnt=num_vec.
- COMPUTE:
  - Beat = x_valid&x_ready.
  - Each beat: next cycle sa_valid=1, sa_input=x_data, sa_switch=first; then first is cleared and vcnt decrements.
  - No beat: sa_valid=0, sa_switch=0, sa_input=0.
  - After the beat with vcnt=1 → DRAIN with dcnt=DRAIN_CYCLES-1.
- DRAIN: sa_* held 0; dcnt decrements; at dcnt=0 → DONE.
- DONE: done=1 for one cycle → IDLE. cmd_ready is 0 in DONE, so back-to-back commands incur one idle cycle.
- Ownership: sa_accept_w and sa_valid are never high in the same cycle. The switch is asserted exactly once per command with num_vec≥1.
- Widths:
  - idx is $clog2(N), wrap never occurs (exit at 0).
  - vcnt is $clog2(MAX_VECTORS+1).
  - cmd_num_vec > MAX_VECTORS is clamped to MAX_VECTORS.

Optional Feature:
- SEQ_PERF_CNT_EN defined: adds outputs perf_stall_cycles (32b) and perf_busy_cycles (32b).
  - perf_stall_cycles counts LOAD/COMPUTE cycles without a beat; perf_busy_cycles counts busy cycles.
  - Both are cleared on cmd acceptance, saturate at all-ones, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package systolic_pkg: state enum (IDLE, LOAD, COMPUTE, DRAIN, DONE), default N/width constants, index/count width localparams.
- One natural sub-module, seq_down_counter: loadable down-counter with terminal-count flag, reused for idx, vcnt and dcnt.

Test Plan:
- Reset check: assert rst mid-COMPUTE → all sa_*=0, busy=0, cmd_ready=1 in the same cycle with no clock; no done.
- Weight load: cmd num_vec=2, 16 continuous weight rows w_data=row r → sa_index goes 15..0 on 16 consecutive cycles with sa_accept_w=1; w_ready drops after the 16th beat.
- Compute: vectors x0=2, x1=3 (all lanes) → sa_valid=1 twice; sa_switch=1 only with x0; done fires DRAIN_CYCLES+1 cycles after the last sa_valid.
- Stalls: w_valid deasserted for 3 cycles mid-load and x_valid toggled every other cycle → sa_accept_w/sa_valid bubbles, index sequence unchanged, exactly one switch.
- Load-only: num_vec=0 → 16 weight beats, no sa_valid or sa_switch, done one cycle after the last sa_accept_w.
- Perf counters (SEQ_PERF_CNT_EN defined): the stall scenario yields perf_stall_cycles equal to the injected bubble count.
